draw_circles_multi: RTL and testbench
=====================================

Name: draw_circles_multi

Overview:
Parametrised successor to the single-object circle/ball drawers. Draws N_OBJ filled circles in one VGA pipeline stage, with per-object position, radius, colour and enable. Object geometry is frame-latched at vertical-blank start, so there is no tearing. Reports per-frame overlap flags for game-logic collision handling. Sits between draw_background and the output registers, in the clk_in pixel domain.

Parameters:
N_OBJ, 3, number of circles (1..8)
POS_W, 12, width of hcount/vcount/xpos/ypos
RAD_W, 8, radius width
COLOR_W, 12, RGB width (4:4:4)

Ports:
clk_in  input  1  pixel clock
rst  input  1  synchronous reset, active-low
hcount_in  input  POS_W  timing horizontal count
hsync_in  input  1  timing hsync
hblnk_in  input  1  timing hblank
vcount_in  input  POS_W  timing vertical count
vsync_in  input  1  timing vsync
vblnk_in  input  1  timing vblank
rgb_in  input  COLOR_W  upstream pixel colour
xpos  input  N_OBJ*POS_W  centre x, object i at [i*POS_W +: POS_W]
ypos  input  N_OBJ*POS_W  centre y, same packing
radius  input  N_OBJ*RAD_W  radius per object
color  input  N_OBJ*COLOR_W  fill colour per object
obj_en  input  N_OBJ  object enable
hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  output  as inputs  timing delayed 2 cycles
rgb_out  output  COLOR_W  composited pixel
hit_mask  output  N_OBJ  overlap flags from the previous frame
frame_tick  output  1  one-cycle pulse when hit_mask updates

Behaviour:
- Reset (rst==0 at a clk_in edge):
  - All outputs go to 0.
  - Latched geometry and latched enables are cleared.
  - Overlap accumulator and vblnk edge register are cleared.
- Frame latch:
  - A vblnk_in rising edge (vblnk_in==1, registered previous==0) copies xpos/ypos/radius/color/obj_en into shadow registers.
  - Inputs changing in the edge cycle are captured with their values in that cycle.
  - Inputs changing elsewhere have no effect until the next edge.
- Stage 1 (per object):
  - dx = hcount_in − x, dy = vcount_in − y, both signed POS_W+1.
  - d2 = dx²+dy², unsigned 2*POS_W+1; r2 = radius², 2*RAD_W, zero-extended.
  - inside_i = en_i && (d2 <= r2). Radius 0 covers only the centre pixel.
  - Timing signals and rgb_in are registered alongside.
- Stage 2 (priority mux):
  - Lowest-index object with inside_i=1 wins: rgb_out = its colour; no hit → rgb_out = delayed rgb_in.
  - Stage-1 hblnk|vblnk=1 forces rgb_out=0.
- Latency: exactly 2 clk_in cycles from every input pixel/timing signal to the matching output. Sync and count outputs are aligned with rgb_out.
- Overlap accumulator:
  - At a stage-2 active (non-blank) pixel where popcount(inside)≥2, OR all covering objects' bits into acc.
- Frame end:
  - On the vblnk_in rising edge, hit_mask <= acc (including any bits set in that same cycle), acc <= 0, frame_tick=1 for one cycle.
  - The shadow geometry is updated in the same cycle.
- No wrap-around handling: centres near a screen edge simply clip; signed subtraction prevents aliasing for coordinates 0..4095.
- Reset mid-frame: drawing is suppressed (latched enables=0) until the first vblnk rising edge after rst returns to 1. Timing still propagates with 2-cycle latency.

Test Plan:
- Reset held 4 cycles mid-line → all outputs 0; after release, rgb_out tracks rgb_in with 2-cycle delay; no circle until the first vblnk edge.
- obj0 at (400,300), r=20, colour FFF, enabled, latched; rgb_in=0F0 → pixel (420,300) is FFF, (421,300) is 0F0, (400,280) is FFF; output appears 2 cycles after input.
- obj0 (FFF) and obj1 (ABC) both at (100,100), r=10 → overlap pixels FFF; next frame_tick gives hit_mask=3'b011.
- Move xpos0 from 400 to 500 mid-frame → current frame still draws at 400; the frame after the vblnk edge draws at 500.
- Objects disjoint for a full frame after an overlapping frame → hit_mask returns to 0 at the next frame_tick; frame_tick is exactly 1 cycle wide, once per frame.
- Radius 0 at (0,0) with obj_en=1 → only pixel (0,0) is coloured. obj_en=0 → no pixel coloured and no hit_mask bit.

Source files
------------

// File: rtl/draw_circles_multi.sv
// Composites N_OBJ filled circles over the incoming VGA stream (2-cycle latency).
// Geometry is shadowed at vblank start; hit_mask reports per-frame overlaps.
module draw_circles_multi #(
    parameter int N_OBJ   = 3,
    parameter int POS_W   = 12,
    parameter int RAD_W   = 8,
    parameter int COLOR_W = 12
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic [POS_W-1:0]           hcount_in,
    input  logic                       hsync_in,
    input  logic                       hblnk_in,
    input  logic [POS_W-1:0]           vcount_in,
    input  logic                       vsync_in,
    input  logic                       vblnk_in,
    input  logic [COLOR_W-1:0]         rgb_in,
    input  logic [N_OBJ*POS_W-1:0]     xpos,
    input  logic [N_OBJ*POS_W-1:0]     ypos,
    input  logic [N_OBJ*RAD_W-1:0]     radius,
    input  logic [N_OBJ*COLOR_W-1:0]   color,
    input  logic [N_OBJ-1:0]           obj_en,
    output logic [POS_W-1:0]           hcount_out,
    output logic                       hsync_out,
    output logic                       hblnk_out,
    output logic [POS_W-1:0]           vcount_out,
    output logic                       vsync_out,
    output logic                       vblnk_out,
    output logic [COLOR_W-1:0]         rgb_out,
    output logic [N_OBJ-1:0]           hit_mask,
    output logic                       frame_tick
);
    localparam int D2_W = 2*POS_W + 1;
    localparam int R2_W = 2*RAD_W;

    logic [N_OBJ-1:0][POS_W-1:0]   sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [N_OBJ-1:0][RAD_W-1:0]   sh_r_q, sh_r_d;
    logic [N_OBJ-1:0][COLOR_W-1:0] sh_col_q, sh_col_d;
    logic [N_OBJ-1:0]              sh_en_q, sh_en_d;
    logic                          vblnk_prev_q, vblnk_prev_d;

    logic [POS_W-1:0]   s1_hcount_q, s1_hcount_d, s1_vcount_q, s1_vcount_d;
    logic               s1_hsync_q, s1_hsync_d, s1_hblnk_q, s1_hblnk_d;
    logic               s1_vsync_q, s1_vsync_d, s1_vblnk_q, s1_vblnk_d;
    logic [COLOR_W-1:0] s1_rgb_q, s1_rgb_d;
    logic [N_OBJ-1:0]   s1_inside_q, s1_inside_d;

    logic [POS_W-1:0]   hcount_out_q, hcount_out_d, vcount_out_q, vcount_out_d;
    logic               hsync_out_q, hsync_out_d, hblnk_out_q, hblnk_out_d;
    logic               vsync_out_q, vsync_out_d, vblnk_out_q, vblnk_out_d;
    logic [COLOR_W-1:0] rgb_out_q, rgb_out_d;
    logic [N_OBJ-1:0]   hit_mask_q, hit_mask_d, acc_q, acc_d;
    logic               frame_tick_q, frame_tick_d;

    logic [N_OBJ-1:0]   inside_c;

    // Distance test uses |dx|,|dy| so the squares stay unsigned and exact.
    for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
        logic signed [POS_W:0] dx, dy, dx_n, dy_n;
        logic [POS_W-1:0]      adx, ady;
        logic [D2_W-1:0]       d2;
        logic [R2_W-1:0]       r2;

        assign dx   = $signed({1'b0, hcount_in}) - $signed({1'b0, sh_x_q[g]});
        assign dy   = $signed({1'b0, vcount_in}) - $signed({1'b0, sh_y_q[g]});
        assign dx_n = -dx;
        assign dy_n = -dy;
        assign adx  = dx[POS_W] ? dx_n[POS_W-1:0] : dx[POS_W-1:0];
        assign ady  = dy[POS_W] ? dy_n[POS_W-1:0] : dy[POS_W-1:0];
        assign d2   = ({{(POS_W+1){1'b0}}, adx} * {{(POS_W+1){1'b0}}, adx})
                    + ({{(POS_W+1){1'b0}}, ady} * {{(POS_W+1){1'b0}}, ady});
        assign r2   = {{RAD_W{1'b0}}, sh_r_q[g]} * {{RAD_W{1'b0}}, sh_r_q[g]};
        assign inside_c[g] = sh_en_q[g] && (d2 <= {{(D2_W-R2_W){1'b0}}, r2});
    end

    logic               vblnk_rise, s1_blank;
    logic [COLOR_W-1:0] rgb_sel;
    logic [3:0]         cover_cnt;
    logic [N_OBJ-1:0]   acc_sum;

    always_comb begin
        vblnk_rise   = vblnk_in & ~vblnk_prev_q;
        vblnk_prev_d = vblnk_in;

        sh_x_d   = sh_x_q;
        sh_y_d   = sh_y_q;
        sh_r_d   = sh_r_q;
        sh_col_d = sh_col_q;
        sh_en_d  = sh_en_q;
        if (vblnk_rise) begin
            sh_x_d   = xpos;
            sh_y_d   = ypos;
            sh_r_d   = radius;
            sh_col_d = color;
            sh_en_d  = obj_en;
        end

        s1_hcount_d = hcount_in;
        s1_hsync_d  = hsync_in;
        s1_hblnk_d  = hblnk_in;
        s1_vcount_d = vcount_in;
        s1_vsync_d  = vsync_in;
        s1_vblnk_d  = vblnk_in;
        s1_rgb_d    = rgb_in;
        s1_inside_d = inside_c;

        hcount_out_d = s1_hcount_q;
        hsync_out_d  = s1_hsync_q;
        hblnk_out_d  = s1_hblnk_q;
        vcount_out_d = s1_vcount_q;
        vsync_out_d  = s1_vsync_q;
        vblnk_out_d  = s1_vblnk_q;

        // Walk high-to-low so the lowest covering index ends up winning.
        rgb_sel   = s1_rgb_q;
        cover_cnt = '0;
        for (int i = N_OBJ-1; i >= 0; i--) begin
            if (s1_inside_q[i]) rgb_sel = sh_col_q[i];
            cover_cnt = cover_cnt + {3'b000, s1_inside_q[i]};
        end
        s1_blank  = s1_hblnk_q | s1_vblnk_q;
        rgb_out_d = s1_blank ? '0 : rgb_sel;

        acc_sum = acc_q;
        if (!s1_blank && cover_cnt >= 4'd2) acc_sum = acc_q | s1_inside_q;

        hit_mask_d   = hit_mask_q;
        acc_d        = acc_sum;
        frame_tick_d = 1'b0;
        if (vblnk_rise) begin
            hit_mask_d   = acc_sum;
            acc_d        = '0;
            frame_tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            sh_x_q <= '0; sh_y_q <= '0; sh_r_q <= '0; sh_col_q <= '0; sh_en_q <= '0;
            vblnk_prev_q <= 1'b0;
            s1_hcount_q <= '0; s1_hsync_q <= 1'b0; s1_hblnk_q <= 1'b0;
            s1_vcount_q <= '0; s1_vsync_q <= 1'b0; s1_vblnk_q <= 1'b0;
            s1_rgb_q <= '0; s1_inside_q <= '0;
            hcount_out_q <= '0; hsync_out_q <= 1'b0; hblnk_out_q <= 1'b0;
            vcount_out_q <= '0; vsync_out_q <= 1'b0; vblnk_out_q <= 1'b0;
            rgb_out_q <= '0; hit_mask_q <= '0; acc_q <= '0; frame_tick_q <= 1'b0;
        end else begin
            sh_x_q <= sh_x_d; sh_y_q <= sh_y_d; sh_r_q <= sh_r_d;
            sh_col_q <= sh_col_d; sh_en_q <= sh_en_d;
            vblnk_prev_q <= vblnk_prev_d;
            s1_hcount_q <= s1_hcount_d; s1_hsync_q <= s1_hsync_d; s1_hblnk_q <= s1_hblnk_d;
            s1_vcount_q <= s1_vcount_d; s1_vsync_q <= s1_vsync_d; s1_vblnk_q <= s1_vblnk_d;
            s1_rgb_q <= s1_rgb_d; s1_inside_q <= s1_inside_d;
            hcount_out_q <= hcount_out_d; hsync_out_q <= hsync_out_d; hblnk_out_q <= hblnk_out_d;
            vcount_out_q <= vcount_out_d; vsync_out_q <= vsync_out_d; vblnk_out_q <= vblnk_out_d;
            rgb_out_q <= rgb_out_d; hit_mask_q <= hit_mask_d; acc_q <= acc_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign hcount_out = hcount_out_q;
    assign hsync_out  = hsync_out_q;
    assign hblnk_out  = hblnk_out_q;
    assign vcount_out = vcount_out_q;
    assign vsync_out  = vsync_out_q;
    assign vblnk_out  = vblnk_out_q;
    assign rgb_out    = rgb_out_q;
    assign hit_mask   = hit_mask_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_draw_circles_multi.sv
// Directed bench for draw_circles_multi: drawing, latency, frame latch, overlap flags, reset.
module tb_draw_circles_multi;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] hcount_in, vcount_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [N*12-1:0] xpos, ypos, color;
    logic [N*8-1:0]  radius;
    logic [N-1:0]    obj_en;
    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out, frame_tick;
    logic [N-1:0] hit_mask;

    int tests_run = 0;
    int fails = 0;

    draw_circles_multi #(.N_OBJ(N), .POS_W(12), .RAD_W(8), .COLOR_W(12)) dut (
        .clk_in(clk), .rst(rst),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .radius(radius),
        .color(color), .obj_en(obj_en),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .hit_mask(hit_mask), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic set_obj(input int i, input logic [11:0] x, input logic [11:0] y,
                           input logic [7:0] r, input logic [11:0] c, input logic en);
        xpos[i*12 +: 12]  = x;
        ypos[i*12 +: 12]  = y;
        radius[i*8 +: 8]  = r;
        color[i*12 +: 12] = c;
        obj_en[i]         = en;
    endtask

    // Holds one active pixel for two clocks; returns at the negedge where its result shows.
    task automatic drive_pix(input logic [11:0] h, input logic [11:0] v, input logic hb);
        hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
    endtask

    // Produces a vblank rising edge; returns where frame_tick should be visible.
    task automatic vblank_rise();
        vblnk_in = 1'b0; hblnk_in = 1'b1;
        @(negedge clk);
        vblnk_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        hcount_in = 12'd123; vcount_in = 12'd45; hsync_in = 1'b1; vsync_in = 1'b1;
        hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = 12'h0F0;
        xpos = '0; ypos = '0; radius = '0; color = '0; obj_en = '0;
        set_obj(0, 12'd400, 12'd300, 8'd20, 12'hFFF, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, hit_mask, frame_tick} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rgb=%h h=%0d v=%0d hs=%b vs=%b hm=%b ft=%b expected all 0",
                     rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, hit_mask, frame_tick);
        end
        rst = 1'b1;
        drive_pix(12'd400, 12'd300, 1'b0);
        tests_run++;
        if (rgb_out !== 12'h0F0 || hcount_out !== 12'd400 || vcount_out !== 12'd300 || hsync_out !== 1'b1) begin
            fails++;
            $display("FAIL reset_passthru: rgb=%h h=%0d v=%0d hs=%b expected 0f0 400 300 1",
                     rgb_out, hcount_out, vcount_out, hsync_out);
        end
        hsync_in = 1'b0; vsync_in = 1'b0;
    endtask

    task automatic test_draw();
        vblank_rise();
        tests_run++;
        if (frame_tick !== 1'b1 || hit_mask !== 3'b000) begin
            fails++;
            $display("FAIL draw_tick: ft=%b hm=%b expected 1 000", frame_tick, hit_mask);
        end
        @(negedge clk);
        tests_run++;
        if (frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL tick_width: ft=%b expected 0", frame_tick);
        end
        hcount_in = 12'd420; vcount_in = 12'd300; hblnk_in = 1'b0; vblnk_in = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rgb_out !== 12'h000) begin
            fails++;
            $display("FAIL latency_early: rgb=%h expected 000", rgb_out);
        end
        @(negedge clk);
        tests_run++;
        if (rgb_out !== 12'hFFF || hcount_out !== 12'd420) begin
            fails++;
            $display("FAIL latency_edge_pix: rgb=%h h=%0d expected fff 420", rgb_out, hcount_out);
        end
        drive_pix(12'd421, 12'd300, 1'b0);
        tests_run++;
        if (rgb_out !== 12'h0F0) begin
            fails++;
            $display("FAIL outside_421: rgb=%h expected 0f0", rgb_out);
        end
        drive_pix(12'd400, 12'd280, 1'b0);
        tests_run++;
        if (rgb_out !== 12'hFFF) begin
            fails++;
            $display("FAIL top_edge_280: rgb=%h expected fff", rgb_out);
        end
        drive_pix(12'd400, 12'd279, 1'b0);
        tests_run++;
        if (rgb_out !== 12'h0F0) begin
            fails++;
            $display("FAIL outside_279: rgb=%h expected 0f0", rgb_out);
        end
        drive_pix(12'd400, 12'd300, 1'b1);
        tests_run++;
        if (rgb_out !== 12'h000 || hblnk_out !== 1'b1) begin
            fails++;
            $display("FAIL hblank_black: rgb=%h hb=%b expected 000 1", rgb_out, hblnk_out);
        end
    endtask

    task automatic test_overlap();
        set_obj(0, 12'd100, 12'd100, 8'd10, 12'hFFF, 1'b1);
        set_obj(1, 12'd100, 12'd100, 8'd10, 12'hABC, 1'b1);
        vblank_rise();
        drive_pix(12'd100, 12'd100, 1'b0);
        tests_run++;
        if (rgb_out !== 12'hFFF) begin
            fails++;
            $display("FAIL overlap_prio: rgb=%h expected fff", rgb_out);
        end
        drive_pix(12'd111, 12'd100, 1'b0);
        tests_run++;
        if (rgb_out !== 12'h0F0) begin
            fails++;
            $display("FAIL overlap_outside: rgb=%h expected 0f0", rgb_out);
        end
        vblank_rise();
        tests_run++;
        if (frame_tick !== 1'b1 || hit_mask !== 3'b011) begin
            fails++;
            $display("FAIL overlap_mask: ft=%b hm=%b expected 1 011", frame_tick, hit_mask);
        end
        @(negedge clk);
        tests_run++;
        if (frame_tick !== 1'b0 || hit_mask !== 3'b011) begin
            fails++;
            $display("FAIL overlap_hold: ft=%b hm=%b expected 0 011", frame_tick, hit_mask);
        end
    endtask

    task automatic test_move();
        set_obj(0, 12'd400, 12'd300, 8'd20, 12'hFFF, 1'b1);
        set_obj(1, 12'd100, 12'd100, 8'd10, 12'hABC, 1'b0);
        vblank_rise();
        tests_run++;
        if (frame_tick !== 1'b1 || hit_mask !== 3'b000) begin
            fails++;
            $display("FAIL disjoint_mask: ft=%b hm=%b expected 1 000", frame_tick, hit_mask);
        end
        drive_pix(12'd420, 12'd300, 1'b0);
        xpos[11:0] = 12'd500;
        drive_pix(12'd420, 12'd300, 1'b0);
        tests_run++;
        if (rgb_out !== 12'hFFF) begin
            fails++;
            $display("FAIL move_old_frame: rgb=%h expected fff", rgb_out);
        end
        drive_pix(12'd520, 12'd300, 1'b0);
        tests_run++;
        if (rgb_out !== 12'h0F0) begin
            fails++;
            $display("FAIL move_not_yet: rgb=%h expected 0f0", rgb_out);
        end
        vblank_rise();
        drive_pix(12'd420, 12'd300, 1'b0);
        tests_run++;
        if (rgb_out !== 12'h0F0) begin
            fails++;
            $display("FAIL move_old_gone: rgb=%h expected 0f0", rgb_out);
        end
        drive_pix(12'd520, 12'd300, 1'b0);
        tests_run++;
        if (rgb_out !== 12'hFFF) begin
            fails++;
            $display("FAIL move_new_pos: rgb=%h expected fff", rgb_out);
        end
    endtask

    task automatic test_radius0_enable();
        set_obj(0, 12'd0, 12'd0, 8'd0, 12'hFFF, 1'b1);
        set_obj(1, 12'd0, 12'd0, 8'd5, 12'hABC, 1'b0);
        vblank_rise();
        drive_pix(12'd0, 12'd0, 1'b0);
        tests_run++;
        if (rgb_out !== 12'hFFF) begin
            fails++;
            $display("FAIL r0_centre: rgb=%h expected fff", rgb_out);
        end
        drive_pix(12'd1, 12'd0, 1'b0);
        tests_run++;
        if (rgb_out !== 12'h0F0) begin
            fails++;
            $display("FAIL r0_right: rgb=%h expected 0f0", rgb_out);
        end
        drive_pix(12'd0, 12'd1, 1'b0);
        tests_run++;
        if (rgb_out !== 12'h0F0) begin
            fails++;
            $display("FAIL r0_below: rgb=%h expected 0f0", rgb_out);
        end
        set_obj(0, 12'd0, 12'd0, 8'd0, 12'hFFF, 1'b0);
        vblank_rise();
        tests_run++;
        if (hit_mask !== 3'b000) begin
            fails++;
            $display("FAIL disabled_no_hit: hm=%b expected 000", hit_mask);
        end
        drive_pix(12'd0, 12'd0, 1'b0);
        tests_run++;
        if (rgb_out !== 12'h0F0) begin
            fails++;
            $display("FAIL disabled_no_draw: rgb=%h expected 0f0", rgb_out);
        end
    endtask

    task automatic test_midframe_reset();
        set_obj(0, 12'd400, 12'd300, 8'd20, 12'hFFF, 1'b1);
        vblank_rise();
        drive_pix(12'd400, 12'd300, 1'b0);
        tests_run++;
        if (rgb_out !== 12'hFFF) begin
            fails++;
            $display("FAIL pre_reset_draw: rgb=%h expected fff", rgb_out);
        end
        rst = 1'b0;
        @(negedge clk); @(negedge clk);
        tests_run++;
        if (rgb_out !== 12'h000 || hcount_out !== 12'd0 || hit_mask !== 3'b000) begin
            fails++;
            $display("FAIL midframe_reset: rgb=%h h=%0d hm=%b expected 000 0 000", rgb_out, hcount_out, hit_mask);
        end
        rst = 1'b1;
        drive_pix(12'd400, 12'd300, 1'b0);
        tests_run++;
        if (rgb_out !== 12'h0F0 || hcount_out !== 12'd400) begin
            fails++;
            $display("FAIL post_reset_suppressed: rgb=%h h=%0d expected 0f0 400", rgb_out, hcount_out);
        end
        vblank_rise();
        drive_pix(12'd400, 12'd300, 1'b0);
        tests_run++;
        if (rgb_out !== 12'hFFF) begin
            fails++;
            $display("FAIL post_reset_relatch: rgb=%h expected fff", rgb_out);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_draw();
        test_overlap();
        test_move();
        test_radius0_enable();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
